// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-return owner tags
// and the default burst limit.
package dmem_pkg;

    localparam int unsigned DMEM_MAX_BURST = 4;

    typedef enum logic [1:0] {
        RR        = 2'd0,
        BURST     = 2'd1,
        FORCE_CPU = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_arb_fsm.sv
// Grant FSM for the CPU/DMA memory port: round-robin arbitration, DMA lock
// bursts bounded by MAX_BURST, and one reserved CPU slot after a long burst.
module dmem_arb_fsm
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_BURST = DMEM_MAX_BURST
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic dma_lock,
    output logic cpu_gnt,
    output logic dma_gnt
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    arb_state_e state_q, state_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    owner_e     last_q, last_d;
    logic       rr_arb;

    always_comb begin
        cpu_gnt     = 1'b0;
        dma_gnt     = 1'b0;
        rr_arb      = 1'b0;
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;

        if (reset) begin
            case (state_q)
                BURST: begin
                    if (dma_req && dma_lock) begin
                        dma_gnt = 1'b1;
                        last_d  = DMA;
                        if (cpu_req) begin
                            burst_cnt_d = burst_cnt_q + 4'd1;
                            if (burst_cnt_d >= MAX_CNT) begin
                                state_d     = FORCE_CPU;
                                burst_cnt_d = '0;
                            end
                        end
                    end else begin
                        // Release cycle is arbitrated like any RR cycle.
                        state_d     = RR;
                        burst_cnt_d = '0;
                        rr_arb      = 1'b1;
                    end
                end
                FORCE_CPU: begin
                    cpu_gnt     = cpu_req;
                    state_d     = RR;
                    burst_cnt_d = '0;
                    last_d      = CPU;
                end
                default: rr_arb = 1'b1;
            endcase

            if (rr_arb) begin
                if (cpu_req && dma_req) begin
                    cpu_gnt = (last_q == DMA);
                    dma_gnt = (last_q != DMA);
                end else begin
                    cpu_gnt = cpu_req;
                    dma_gnt = dma_req;
                end
                if (cpu_gnt) begin
                    last_d = CPU;
                end
                if (dma_gnt) begin
                    last_d = DMA;
                    if (dma_lock) begin
                        state_d     = BURST;
                        burst_cnt_d = 4'd1;
                        // With a limit of one, the opening grant already exhausts the burst.
                        if (cpu_req && (MAX_CNT <= 4'd1)) begin
                            state_d     = FORCE_CPU;
                            burst_cnt_d = '0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RR;
            burst_cnt_q <= '0;
            last_q      <= DMA;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory shared by the CPU E stage and the audio DMA: grant
// FSM, request mux onto the memory port, and one-cycle read return routing.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int unsigned MAX_BURST = DMEM_MAX_BURST,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_stall,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    input  logic          dma_req,
    input  logic          dma_lock,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    logic          cpu_gnt;
    logic          dma_gnt_w;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    owner_e        owner_q, owner_d;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] dma_rdata_q;

    dmem_arb_fsm #(
        .MAX_BURST(MAX_BURST)
    ) u_fsm (
        .clk     (clk),
        .reset   (reset),
        .cpu_req (cpu_req),
        .dma_req (dma_req),
        .dma_lock(dma_lock),
        .cpu_gnt (cpu_gnt),
        .dma_gnt (dma_gnt_w)
    );

    assign dma_gnt   = dma_gnt_w;
    assign cpu_stall = reset & cpu_req & ~cpu_gnt;

    always_comb begin
        mem_en    = cpu_gnt | dma_gnt_w;
        mem_we    = 1'b0;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        owner_d   = NONE;
        if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            if (!cpu_we) begin
                owner_d = CPU;
            end
        end else if (dma_gnt_w) begin
            mem_we    = dma_we;
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            if (!dma_we) begin
                owner_d = DMA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            owner_q     <= NONE;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (mem_en) begin
                addr_q  <= mem_addr;
                wdata_q <= mem_wdata;
            end
            owner_q <= owner_d;
            if (owner_q == CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (owner_q == DMA) begin
                dma_rdata_q <= mem_rdata;
            end
        end
    end

    // Returning data is passed straight through; the _q copy holds it afterwards.
    assign cpu_rvalid = (owner_q == CPU);
    assign dma_rvalid = (owner_q == DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dma_rdata  = dma_rvalid ? mem_rdata : dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then randomized traffic, all
// checked against a behavioural arbitration/memory model.
module tb_dmem_arbiter;

    localparam int MB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_lock, dma_we;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, mem_en, mem_we;
    logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];

    int n_vec = 0;
    int n_err = 0;

    // Model state
    bit          m_last_cpu, m_locked, m_owe;
    int          m_streak;
    logic [31:0] m_addr, m_wdata;
    bit          m_cpv, m_dpv;
    logic [31:0] m_cpval, m_dpval, m_chold, m_dhold;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .MAX_BURST(MB),
        .AW       (32),
        .DW       (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_stall (cpu_stall),
        .cpu_rdata (cpu_rdata),
        .cpu_rvalid(cpu_rvalid),
        .dma_req   (dma_req),
        .dma_lock  (dma_lock),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_gnt   (dma_gnt),
        .dma_rdata (dma_rdata),
        .dma_rvalid(dma_rvalid),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous single-port memory driven by the DUT's memory port
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[5:2]];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, check the DUT before the edge, advance the model.
    task automatic cycle(input bit rst,
                         input bit creq, input bit cwe, input logic [31:0] caddr, input logic [31:0] cwd,
                         input bit dreq, input bit dlock, input bit dwe,
                         input logic [31:0] daddr, input logic [31:0] dwd);
        bit          gc, gd, ewe;
        logic [31:0] ea, ew;
        @(negedge clk);
        reset = rst; cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = dreq; dma_lock = dlock; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
        #1;
        gc = 0; gd = 0;
        if (rst) begin
            if (m_owe)                         gc = creq;
            else if (m_locked && dreq && dlock) gd = 1;
            else if (creq && dreq)             begin gc = !m_last_cpu; gd = m_last_cpu; end
            else                               begin gc = creq; gd = dreq; end
        end
        ea = m_addr; ew = m_wdata; ewe = 0;
        if (gc)      begin ea = caddr; ew = cwd; ewe = cwe; end
        else if (gd) begin ea = daddr; ew = dwd; ewe = dwe; end

        chk("cpu_stall",  cpu_stall,  rst && creq && !gc);
        chk("dma_gnt",    dma_gnt,    gd);
        chk("mem_en",     mem_en,     gc || gd);
        chk("mem_we",     mem_we,     ewe);
        chk("mem_addr",   mem_addr,   ea);
        chk("mem_wdata",  mem_wdata,  ew);
        chk("cpu_rvalid", cpu_rvalid, m_cpv);
        chk("dma_rvalid", dma_rvalid, m_dpv);
        chk("cpu_rdata",  cpu_rdata,  m_cpv ? m_cpval : m_chold);
        chk("dma_rdata",  dma_rdata,  m_dpv ? m_dpval : m_dhold);

        if (!rst) begin
            m_last_cpu = 0; m_locked = 0; m_owe = 0; m_streak = 0;
            m_addr = '0; m_wdata = '0;
            m_cpv = 0; m_dpv = 0; m_chold = '0; m_dhold = '0;
        end else begin
            if (m_cpv) m_chold = m_cpval;
            if (m_dpv) m_dhold = m_dpval;
            m_cpv   = gc && !cwe;
            m_dpv   = gd && !dwe;
            m_cpval = ref_mem[caddr[5:2]];
            m_dpval = ref_mem[daddr[5:2]];
            if (gc || gd) begin
                m_addr = ea; m_wdata = ew;
                if (ewe) ref_mem[ea[5:2]] = ew;
            end
            if (m_owe) begin
                m_owe = 0; m_last_cpu = 1;
            end else if (m_locked && dreq && dlock) begin
                m_last_cpu = 0;
                if (creq) m_streak++;
                if (creq && m_streak >= MB) begin m_owe = 1; m_locked = 0; end
            end else begin
                m_locked = 0; m_streak = 0;
                if (gc) m_last_cpu = 1;
                if (gd) begin
                    m_last_cpu = 0;
                    if (dlock) begin
                        m_locked = 1; m_streak = 1;
                        if (creq && MB <= 1) begin m_owe = 1; m_locked = 0; end
                    end
                end
            end
        end
    endtask

    initial begin
        logic [5:0] burst_pat;
        burst_pat = 6'b101111;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom; ref_mem[i] = mem[i];
        end
        mem[4] = 32'hCAFE0001; ref_mem[4] = 32'hCAFE0001;
        reset = 0; cpu_req = 0; cpu_we = 0; dma_req = 0; dma_lock = 0; dma_we = 0;
        cpu_addr = '0; cpu_wdata = '0; dma_addr = '0; dma_wdata = '0;
        m_last_cpu = 0; m_locked = 0; m_owe = 0; m_streak = 0;
        m_addr = '0; m_wdata = '0; m_cpv = 0; m_dpv = 0;
        m_cpval = '0; m_dpval = '0; m_chold = '0; m_dhold = '0;

        // Requests held under reset must produce no activity
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 0, 32'h0, 32'h0, 1, 1, 1, 32'h8, 32'h1);
            chk("rst_en", mem_en, 0);
            chk("rst_we", mem_we, 0);
            chk("rst_gnt", dma_gnt, 0);
            chk("rst_stall", cpu_stall, 0);
        end

        // Tie alternates starting with CPU
        for (int i = 0; i < 4; i++) begin
            cycle(1, 1, 0, 32'h0, 32'h0, 1, 0, 0, 32'h8, 32'h0);
            chk("tie_stall", cpu_stall, 64'(i % 2));
            chk("tie_dgnt", dma_gnt, 64'(i % 2));
        end

        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
            chk("idle_en", mem_en, 0);
            chk("idle_stall", cpu_stall, 0);
            chk("idle_gnt", dma_gnt, 0);
        end

        // Burst fairness: leave last grant on CPU, then hold everything
        cycle(1, 1, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 6; i++) begin
            cycle(1, 1, 0, 32'h0, 32'h0, 1, 1, 0, 32'h0, 32'h0);
            chk("burst_dgnt", dma_gnt, 64'(burst_pat[i]));
        end
        cycle(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);

        // Read return
        cycle(1, 1, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        cycle(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        chk("rd_cpu_rvalid", cpu_rvalid, 1);
        chk("rd_cpu_rdata", cpu_rdata, 32'hCAFE0001);
        chk("rd_dma_rvalid", dma_rvalid, 0);

        // Back-to-back DMA read then CPU write
        cycle(1, 0, 0, 32'h0, 32'h0, 1, 0, 0, 32'h20, 32'h0);
        chk("b2b_en0", mem_en, 1);
        cycle(1, 1, 1, 32'h24, 32'h55, 0, 0, 0, 32'h0, 32'h0);
        chk("b2b_en1", mem_en, 1);
        chk("b2b_dma_rvalid", dma_rvalid, 1);
        chk("b2b_cpu_rvalid", cpu_rvalid, 0);
        cycle(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        chk("b2b_cpu_rvalid2", cpu_rvalid, 0);

        // Reset during a burst with a read in flight
        cycle(1, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h20, 32'h0);
        cycle(1, 1, 0, 32'h4, 32'h0, 1, 1, 0, 32'h24, 32'h0);
        chk("rb_burst_gnt", dma_gnt, 1);
        cycle(0, 1, 0, 32'h4, 32'h0, 1, 1, 0, 32'h24, 32'h0);
        cycle(1, 1, 0, 32'h4, 32'h0, 1, 0, 0, 32'h24, 32'h0);
        chk("rb_cpu_rvalid", cpu_rvalid, 0);
        chk("rb_dma_rvalid", dma_rvalid, 0);
        chk("rb_tie_stall", cpu_stall, 0);
        chk("rb_tie_dgnt", dma_gnt, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 63) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0,
                  {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
